// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Per-cycle stall/flush generator for the 5-stage core.
//                Resolves load-use, EX redirects, memory wait states,
//                multi-cycle mul/div occupancy and MEM-stage traps.
//                Optional macro HAZARD_PERF_EN adds stall/flush counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int REG_W             = 5,
    parameter int TRAP_FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_redirect,
    input  logic             ex_md_start,
    input  logic             md_done,
    input  logic             mem_trap,
    input  logic             imem_wait,
    input  logic             dmem_wait,
    output logic             stall_pc,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             stall_ex_mem,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             flush_ex_mem,
    output logic             flush_mem_wb,
    output logic             md_kill
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_flush_events
`endif
);

    localparam int               CNT_W     = $clog2(TRAP_FLUSH_CYCLES + 1);
    localparam logic [CNT_W-1:0] TRAP_LOAD = CNT_W'(TRAP_FLUSH_CYCLES - 1);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MD_WAIT = 2'd1;
    localparam logic [1:0] S_TRAP    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] trap_cnt_q, trap_cnt_d;
    logic             load_use;

    // ID instruction needs a value the EX load has not produced yet (x0 never hazards)
    assign load_use = ex_is_load && (ex_rd != '0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    // State and trap counter registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_RUN;
            trap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            trap_cnt_q <= trap_cnt_d;
        end
    end

    // Next-state selection following the hazard priority order
    always_comb begin
        state_d    = state_q;
        trap_cnt_d = trap_cnt_q;
        if (mem_trap) begin
            state_d    = S_TRAP;
            trap_cnt_d = TRAP_LOAD;
        end else if (state_q == S_TRAP) begin
            if (trap_cnt_q == '0) begin
                state_d = S_RUN;
            end else begin
                trap_cnt_d = trap_cnt_q - 1'b1;
            end
        end else if (dmem_wait) begin
            // Memory wait freezes the FSM, but a finishing mul/div is not lost
            if ((state_q == S_MD_WAIT) && md_done) begin
                state_d = S_RUN;
            end
        end else if ((state_q == S_MD_WAIT) && !md_done) begin
            state_d = S_MD_WAIT;
        end else if ((state_q != S_MD_WAIT) && ex_md_start && !md_done) begin
            state_d = S_MD_WAIT;
        end else begin
            // Also recovers from the unused encoding
            state_d = S_RUN;
        end
    end

    // Output decode from current state and inputs
    always_comb begin
        stall_pc     = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        flush_mem_wb = 1'b0;
        md_kill      = 1'b0;
        if (!reset_n) begin
            // Keep every stage empty while the core is held in reset
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (mem_trap) begin
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
            md_kill      = (state_q == S_MD_WAIT);
        end else if (state_q == S_TRAP) begin
            flush_if_id = 1'b1;
        end else if (dmem_wait) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (((state_q == S_MD_WAIT) || ex_md_start) && !md_done) begin
            // Hold front end on the mul/div; EX/MEM receives bubbles meanwhile
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (ex_redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (imem_wait) begin
            stall_pc    = 1'b1;
            flush_if_id = 1'b1;
        end
    end

`ifdef HAZARD_PERF_EN
    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            perf_stall_cycles <= '0;
            perf_flush_events <= '0;
        end else begin
            if (stall_pc) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (flush_id_ex || flush_ex_mem) begin
                perf_flush_events <= perf_flush_events + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire
